// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with a sequential binary-to-BCD converter.
// Latency: decimal load commits DATA_W+1 clks after capture, hex load 1 clk; scan output registered.
// Backpressure: busy is high while converting; a load seen while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   data_in        binary value captured on load (with hex_mode)
//   load           1-cycle capture request, honoured only when !busy
//   hex_mode       1 = hex nibbles, 0 = decimal (sampled at load)
//   blank_lz       blank leading zero digits (live)
//   dp_in          per-digit decimal point enable (live)
//   busy           conversion in progress
//   ovf            committed value does not fit in N_DIGITS (all digits show a dash)
//   seven_seg_out  {a,b,c,d,e,f,g,dp}, active-low, registered
//   select         one-cold active-low digit enable, bit i = digit i (0 = ones)
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int DATA_W      = 12,
  parameter int REFRESH_DIV = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load,
  input  logic                hex_mode,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_in,
  output logic                busy,
  output logic                ovf,
  output logic [7:0]          seven_seg_out,
  output logic [N_DIGITS-1:0] select
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       work_bcd;
  logic [BW-1:0]       adj_bcd;
  logic [DATA_W-1:0]   work_bin;
  logic                work_ovf;
  logic [CW-1:0]       bit_cnt;
  logic [BW-1:0]       disp_bcd;
  logic [BW+DATA_W-1:0] ext;
  logic                hex_hi;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [IW-1:0]       scan_idx;
  logic [N_DIGITS-1:0] zero_up;
  logic                zero_run;
  logic [3:0]          nib;
  logic [7:0]          seg_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign busy = (state != IDLE);

  // Zero-extended copy of the input: low BW bits are the hex digits, anything above
  // them flags a hex value too wide for the display.
  assign ext    = {{BW{1'b0}}, data_in};
  assign hex_hi = |ext[BW+DATA_W-1:BW];

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = hex_mode ? DONE : SHIFT;
      SHIFT:   if (bit_cnt == CW'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj_bcd = work_bcd;
    for (int n = 0; n < N_DIGITS; n++) begin
      if (work_bcd[4*n +: 4] >= 4'd5) adj_bcd[4*n +: 4] = work_bcd[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_bcd <= '0;
      work_bin <= '0;
      work_ovf <= 1'b0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bit_cnt <= '0;
            if (hex_mode) begin
              work_bcd <= ext[BW-1:0];
              work_ovf <= hex_hi;
            end else begin
              work_bcd <= '0;
              work_bin <= data_in;
              work_ovf <= 1'b0;
            end
          end
        end
        SHIFT: begin
          // A 1 leaving the top nibble means the value needs more digits than we have.
          work_bcd <= {adj_bcd[BW-2:0], work_bin[DATA_W-1]};
          work_bin <= work_bin << 1;
          work_ovf <= work_ovf | adj_bcd[BW-1];
          bit_cnt  <= bit_cnt + CW'(1);
        end
        DONE: begin
          disp_bcd <= work_bcd;
          ovf      <= work_ovf;
        end
        default: ;
      endcase
    end
  end

  // ---------------- refresh prescaler ----------------
  assign tick = (presc == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // ---------------- digit pattern ----------------
  // zero_up[i]: digit i and every digit above it are zero.
  always_comb begin
    zero_run = 1'b1;
    zero_up  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_bcd[4*i +: 4] == 4'd0);
      zero_up[i] = zero_run;
    end
  end

  assign nib = disp_bcd[{scan_idx, 2'b00} +: 4];

  always_comb begin
    seg_nxt = {glyph(nib), ~dp_in[scan_idx]};
    if (ovf)
      seg_nxt[7:1] = 7'b1111110;
    else if (blank_lz && (scan_idx != '0) && zero_up[scan_idx])
      seg_nxt[7:1] = 7'b1111111;
  end

  // ---------------- scan ----------------
  // scan_idx holds the digit shown at the next tick, so the first tick after
  // reset lights the most significant digit and the order then descends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx      <= IW'(N_DIGITS - 1);
      select        <= '1;
      seven_seg_out <= 8'hFF;
    end else if (tick) begin
      scan_idx      <= (scan_idx == '0) ? IW'(N_DIGITS - 1) : scan_idx - IW'(1);
      select        <= ~(N_DIGITS'(1) << scan_idx);
      seven_seg_out <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data_in;
  logic        load4, load3, hex_mode, blank_lz;
  logic [3:0]  dp4;
  logic [2:0]  dp3;
  logic        busy4, ovf4, busy3, ovf3;
  logic [7:0]  seg4, seg3;
  logic [3:0]  sel4;
  logic [2:0]  sel3;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(4), .DATA_W(12), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load4), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_in(dp4), .busy(busy4), .ovf(ovf4),
    .seven_seg_out(seg4), .select(sel4));

  seg7_scan_driver #(.N_DIGITS(3), .DATA_W(12), .REFRESH_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load3), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_in(dp3), .busy(busy3), .ovf(ovf3),
    .seven_seg_out(seg3), .select(sel3));

  typedef struct {int val; bit hex;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;  6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100; 10: return 7'b0001000; 11: return 7'b1100000;
     12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  function automatic bit ref_ovf(input int n, input int val, input bit hex);
    int p = 1;
    for (int j = 0; j < n; j++) p = p * 10;
    return hex ? ((val >> (4 * n)) != 0) : (val >= p);
  endfunction

  function automatic logic [7:0] ref_seg(input int n, input int val, input bit hex,
                                         input bit blz, input logic [3:0] dp, input int i);
    int d[4];
    int p = 1;
    bit lz;
    for (int j = 0; j < 4; j++) d[j] = 0;
    for (int j = 0; j < n; j++) begin
      d[j] = hex ? ((val >> (4 * j)) & 15) : ((val / p) % 10);
      p = p * 10;
    end
    lz = blz && (i > 0);
    for (int j = i; j < n; j++) if (d[j] != 0) lz = 1'b0;
    if (ref_ovf(n, val, hex)) return {7'b1111110, ~dp[i]};
    if (lz) return {7'b1111111, ~dp[i]};
    return {ref_glyph(d[i]), ~dp[i]};
  endfunction

  // ---------------- instance accessors ----------------
  function automatic logic [3:0] get_sel(input int u);
    return (u == 0) ? sel4 : {1'b1, sel3};
  endfunction
  function automatic logic [7:0] get_seg(input int u);
    return (u == 0) ? seg4 : seg3;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 0) ? busy4 : busy3;
  endfunction
  function automatic logic get_ovf(input int u);
    return (u == 0) ? ovf4 : ovf3;
  endfunction
  function automatic logic [3:0] get_dp(input int u);
    return (u == 0) ? dp4 : {1'b0, dp3};
  endfunction

  // ---------------- stimulus / capture tasks ----------------
  task automatic pulse_load(input int u, input int val, input bit hex);
    @(negedge clk);
    data_in  = 12'(val);
    hex_mode = hex;
    if (u == 0) load4 = 1'b1; else load3 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    load3 = 1'b0;
  endtask

  // Wait for select to move onto digit i (a fresh scan slot, so seg reflects current state).
  task automatic wait_digit(input int u, input int i, output bit ok);
    logic [3:0] prev, tgt;
    tgt  = ~(4'b0001 << i);
    prev = get_sel(u);
    ok   = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (get_sel(u) != prev && get_sel(u) == tgt) ok = 1'b1;
      prev = get_sel(u);
    end
  endtask

  task automatic check_display(input int u, input int n, input exp_t e);
    bit ok;
    for (int i = n - 1; i >= 0; i--) begin
      wait_digit(u, i, ok);
      chk($sformatf("u%0d_dig%0d_found", u, i), ok, 1);
      chk($sformatf("u%0d_dig%0d_seg", u, i), get_seg(u),
          ref_seg(n, e.val, e.hex, blank_lz, get_dp(u), i));
    end
  endtask

  task automatic run_load(input int u, input int val, input bit hex, input int n);
    exp_t e;
    int   cnt;
    sb.push_back('{val, hex});
    pulse_load(u, val, hex);
    cnt = 0;
    while (get_busy(u) && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("u%0d_busy_cycles_%0d", u, val), cnt, hex ? 1 : 13);
    e = sb.pop_front();
    chk($sformatf("u%0d_ovf_%0d", u, val), get_ovf(u), ref_ovf(n, e.val, e.hex));
    check_display(u, n, e);
  endtask

  task automatic wait_change(output int n, output bit ok);
    logic [3:0] p;
    p  = sel4;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 32) begin
      @(negedge clk);
      n++;
      if (sel4 != p) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] scan_exp[5];
    exp_t e;
    int   n, cnt, rises;
    bit   ok;

    scan_exp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
    rst_n = 1'b0; data_in = '0; load4 = 1'b0; load3 = 1'b0; hex_mode = 1'b0;
    blank_lz = 1'b0; dp4 = '0; dp3 = '0;

    #12;
    chk("rst_busy", busy4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_sel", sel4, 4'b1111);
    chk("rst_seg", seg4, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a decimal conversion
    pulse_load(0, 999, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", busy4, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy4, 0);
    chk("midrst_ovf", ovf4, 0);
    chk("midrst_sel", sel4, 4'b1111);
    chk("midrst_seg", seg4, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan order and spacing
    for (int s = 0; s < 5; s++) begin
      wait_change(n, ok);
      chk($sformatf("scan%0d_found", s), ok, 1);
      chk($sformatf("scan%0d_sel", s), sel4, scan_exp[s]);
      if (s > 0) chk($sformatf("scan%0d_gap", s), n, 4);
      if (scan_exp[s] == 4'b1110) chk("scan_d0_seg", seg4, 8'b00000011);
    end

    // Decimal 999 with leading-zero blanking and a DP on digit 1
    blank_lz = 1'b1;
    dp4 = 4'b0010;
    run_load(0, 999, 1'b0, 4);

    // A second load while busy must be dropped
    blank_lz = 1'b0;
    dp4 = 4'b0000;
    sb.push_back('{5, 1'b0});
    pulse_load(0, 5, 1'b0);
    data_in = 12'd7;
    load4 = 1'b1;
    cnt = 0;
    while (busy4 && cnt < 64) begin
      cnt++;
      @(negedge clk);
      load4 = 1'b0;
    end
    load4 = 1'b0;
    chk("ignore_busy_cycles", cnt, 13);
    rises = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy4) rises++;
    end
    chk("ignore_no_restart", rises, 0);
    e = sb.pop_front();
    chk("ignore_ovf", ovf4, ref_ovf(4, e.val, e.hex));
    check_display(0, 4, e);

    // Hex value with all digits shown
    run_load(0, 12'hABC, 1'b1, 4);

    // Three-digit instance: overflow then recovery
    run_load(1, 4095, 1'b0, 3);
    run_load(1, 42, 1'b0, 3);
    blank_lz = 1'b1;
    e = '{42, 1'b0};
    check_display(1, 3, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
